// File: rtl/uvmt_cv32e40x_exceptions_trap_checker.sv
// Illegal-instruction trap checker: follows an illegal retirement to the first handler retirement and checks vector, mcause and mepc.
// Optional SVA assertions and covers are enabled with UVMT_CV32E40X_EXCEPTIONS_TRAP_CHECK_ASSERT_EN.
module uvmt_cv32e40x_exceptions_trap_checker #(
  parameter int unsigned TIMEOUT        = 64,
  parameter logic [31:0] MCAUSE_ILLEGAL = 32'h0000_0002
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        wb_valid,
  input  logic        illegal_insn,
  input  logic [31:0] wb_pc,
  input  logic        debug_mode,
  input  logic [31:0] mcause_q,
  input  logic [31:0] mepc_q,
  input  logic [31:0] mtvec_q,
  output logic        busy,
  output logic        err_vector,
  output logic        err_mcause,
  output logic        err_mepc,
  output logic        err_timeout,
  output logic [31:0] illegal_cnt,
  output logic [31:0] handled_cnt
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  typedef enum logic {IDLE, WAIT_HANDLER} state_t;

  state_t        state, state_n;
  logic [31:0]   pc_l, pc_l_n;
  logic [TW-1:0] timer, timer_n;
  logic          err_vector_n, err_mcause_n, err_mepc_n, err_timeout_n;
  logic [31:0]   illegal_cnt_n, handled_cnt_n;
  logic          trigger, vector_ok, mcause_ok, mepc_ok;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Exceptions never vector, so the handler always starts at the mtvec base.
  assign trigger   = wb_valid && illegal_insn && !debug_mode;
  assign vector_ok = (wb_pc == (mtvec_q & 32'hFFFF_FFFC));
  assign mcause_ok = (mcause_q == MCAUSE_ILLEGAL);
  assign mepc_ok   = (mepc_q == pc_l);
  assign busy      = (state == WAIT_HANDLER);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state       <= IDLE;
      pc_l        <= '0;
      timer       <= '0;
      err_vector  <= 1'b0;
      err_mcause  <= 1'b0;
      err_mepc    <= 1'b0;
      err_timeout <= 1'b0;
      illegal_cnt <= '0;
      handled_cnt <= '0;
    end else begin
      state       <= state_n;
      pc_l        <= pc_l_n;
      timer       <= timer_n;
      err_vector  <= err_vector_n;
      err_mcause  <= err_mcause_n;
      err_mepc    <= err_mepc_n;
      err_timeout <= err_timeout_n;
      illegal_cnt <= illegal_cnt_n;
      handled_cnt <= handled_cnt_n;
    end
  end

  // Debug abort outranks everything in WAIT_HANDLER; handler entry outranks the timeout.
  always_comb begin
    state_n       = state;
    pc_l_n        = pc_l;
    timer_n       = timer;
    err_vector_n  = err_vector;
    err_mcause_n  = err_mcause;
    err_mepc_n    = err_mepc;
    err_timeout_n = err_timeout;
    illegal_cnt_n = illegal_cnt;
    handled_cnt_n = handled_cnt;
    case (state)
      IDLE: begin
        if (trigger) begin
          pc_l_n        = wb_pc;
          timer_n       = '0;
          illegal_cnt_n = sat_inc(illegal_cnt);
          state_n       = WAIT_HANDLER;
        end
      end
      WAIT_HANDLER: begin
        if (debug_mode) begin
          state_n = IDLE;
        end else if (wb_valid) begin
          if (!vector_ok) err_vector_n = 1'b1;
          if (!mcause_ok) err_mcause_n = 1'b1;
          if (!mepc_ok)   err_mepc_n   = 1'b1;
          if (vector_ok && mcause_ok && mepc_ok) handled_cnt_n = sat_inc(handled_cnt);
          if (illegal_insn) begin
            pc_l_n        = wb_pc;
            timer_n       = '0;
            illegal_cnt_n = sat_inc(illegal_cnt);
          end else begin
            state_n = IDLE;
          end
        end else if (timer == TIMER_LAST) begin
          err_timeout_n = 1'b1;
          state_n       = IDLE;
        end else begin
          timer_n = timer + TW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

`ifdef UVMT_CV32E40X_EXCEPTIONS_TRAP_CHECK_ASSERT_EN
  logic entry;
  assign entry = (state == WAIT_HANDLER) && !debug_mode && wb_valid;

  a_vector: assert property (@(posedge clk_i) disable iff (!rst_ni) entry |-> vector_ok)
    else $error("trap handler pc mismatch: pc_l=%h wb_pc=%h", pc_l, wb_pc);
  a_mcause: assert property (@(posedge clk_i) disable iff (!rst_ni) entry |-> mcause_ok)
    else $error("trap mcause mismatch: pc_l=%h mcause_q=%h", pc_l, mcause_q);
  a_mepc: assert property (@(posedge clk_i) disable iff (!rst_ni) entry |-> mepc_ok)
    else $error("trap mepc mismatch: pc_l=%h mepc_q=%h", pc_l, mepc_q);
  a_timeout: assert property (@(posedge clk_i) disable iff (!rst_ni)
      ((state == WAIT_HANDLER) && !debug_mode && !wb_valid) |-> (timer != TIMER_LAST))
    else $error("trap handler timeout: pc_l=%h timer=%0d", pc_l, timer);

  c_entry: cover property (@(posedge clk_i) disable iff (!rst_ni) entry);
  c_rearm: cover property (@(posedge clk_i) disable iff (!rst_ni) entry && illegal_insn);
  c_abort: cover property (@(posedge clk_i) disable iff (!rst_ni) (state == WAIT_HANDLER) && debug_mode);
`endif

endmodule

// File: tb/tb_uvmt_cv32e40x_exceptions_trap_checker.sv
// Self-checking bench for uvmt_cv32e40x_exceptions_trap_checker: directed vector table, hand-written corners, random vs. reference model.
module tb_uvmt_cv32e40x_exceptions_trap_checker;

  localparam int unsigned TIMEOUT = 4;
  localparam logic [31:0] MTVEC  = 32'h0000_1001;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        wb_valid = 1'b0;
  logic        illegal_insn = 1'b0;
  logic [31:0] wb_pc = '0;
  logic        debug_mode = 1'b0;
  logic [31:0] mcause_q = '0;
  logic [31:0] mepc_q = '0;
  logic [31:0] mtvec_q = MTVEC;
  logic        busy, err_vector, err_mcause, err_mepc, err_timeout;
  logic [31:0] illegal_cnt, handled_cnt;

  int checks = 0;
  int fails  = 0;

  uvmt_cv32e40x_exceptions_trap_checker #(
    .TIMEOUT(TIMEOUT),
    .MCAUSE_ILLEGAL(32'h0000_0002)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .wb_valid(wb_valid), .illegal_insn(illegal_insn),
    .wb_pc(wb_pc), .debug_mode(debug_mode), .mcause_q(mcause_q), .mepc_q(mepc_q),
    .mtvec_q(mtvec_q), .busy(busy), .err_vector(err_vector), .err_mcause(err_mcause),
    .err_mepc(err_mepc), .err_timeout(err_timeout), .illegal_cnt(illegal_cnt),
    .handled_cnt(handled_cnt)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        rst_n;
    logic        v;
    logic        ill;
    logic [31:0] pc;
    logic        dbg;
    logic [31:0] mc;
    logic [31:0] me;
    logic [31:0] mt;
  } stim_t;

  typedef struct {
    stim_t       s;
    logic [68:0] exp;
  } vec_t;

  function automatic logic [68:0] ex(input logic b, input logic [3:0] e, input int ic, input int hc);
    return {b, e, 32'(ic), 32'(hc)};
  endfunction

  function automatic stim_t st(input logic r, input logic v, input logic il, input logic [31:0] pc,
                               input logic d, input logic [31:0] mc, input logic [31:0] me);
    stim_t s;
    s.rst_n = r; s.v = v; s.ill = il; s.pc = pc; s.dbg = d; s.mc = mc; s.me = me; s.mt = MTVEC;
    return s;
  endfunction

  task automatic applyStimulus(input stim_t s);
    rst_ni       = s.rst_n;
    wb_valid     = s.v;
    illegal_insn = s.ill;
    wb_pc        = s.pc;
    debug_mode   = s.dbg;
    mcause_q     = s.mc;
    mepc_q       = s.me;
    mtvec_q      = s.mt;
    @(posedge clk_i);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [68:0] exp);
    logic [68:0] act;
    act = {busy, err_vector, err_mcause, err_mepc, err_timeout, illegal_cnt, handled_cnt};
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got busy=%b err(vec/cause/epc/to)=%b ill=%0d hand=%0d, expected busy=%b err=%b ill=%0d hand=%0d",
               name, act[68], act[67:64], act[63:32], act[31:0], exp[68], exp[67:64], exp[63:32], exp[31:0]);
    end
  endtask

  // Reference model: one pending check, counted in elapsed handler-wait cycles.
  bit          m_pending;
  logic [31:0] m_pc;
  int          m_elapsed;
  bit          m_ev, m_em, m_ep, m_et;
  longint      m_ic, m_hc;

  function automatic longint sat(input longint v);
    return (v >= 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : v + 1;
  endfunction

  task automatic model_step(input stim_t s);
    bit ok_v, ok_c, ok_e;
    if (!s.rst_n) begin
      m_pending = 0; m_pc = '0; m_elapsed = 0;
      m_ev = 0; m_em = 0; m_ep = 0; m_et = 0; m_ic = 0; m_hc = 0;
    end else if (m_pending) begin
      if (s.dbg) begin
        m_pending = 0;
      end else if (s.v) begin
        ok_v = (s.pc == {s.mt[31:2], 2'b00});
        ok_c = (s.mc == 32'd2);
        ok_e = (s.me == m_pc);
        if (!ok_v) m_ev = 1;
        if (!ok_c) m_em = 1;
        if (!ok_e) m_ep = 1;
        if (ok_v && ok_c && ok_e) m_hc = sat(m_hc);
        if (s.ill) begin
          m_pc = s.pc; m_elapsed = 0; m_ic = sat(m_ic);
        end else begin
          m_pending = 0;
        end
      end else begin
        m_elapsed++;
        if (m_elapsed >= int'(TIMEOUT)) begin
          m_et = 1; m_pending = 0;
        end
      end
    end else if (s.v && s.ill && !s.dbg) begin
      m_pending = 1; m_pc = s.pc; m_elapsed = 0; m_ic = sat(m_ic);
    end
  endtask

  function automatic logic [68:0] model_exp();
    return {m_pending, m_ev, m_em, m_ep, m_et, m_ic[31:0], m_hc[31:0]};
  endfunction

  function automatic stim_t random_stim();
    stim_t s;
    logic [31:0] mts [3];
    logic [31:0] pcs [4];
    mts[0] = 32'h0000_1000; mts[1] = 32'h0000_1001; mts[2] = 32'h0000_2003;
    pcs[0] = 32'h100; pcs[1] = 32'h104; pcs[2] = 32'h200; pcs[3] = 32'h1000;
    s.rst_n = ($urandom_range(0, 99) != 0);
    s.v     = ($urandom_range(0, 2) == 0);
    s.ill   = ($urandom_range(0, 1) == 0);
    s.mt    = mts[$urandom_range(0, 2)];
    s.pc    = (m_pending && $urandom_range(0, 3) != 0) ? {s.mt[31:2], 2'b00} : pcs[$urandom_range(0, 3)];
    s.dbg   = !s.v && ($urandom_range(0, 15) == 0);
    s.mc    = ($urandom_range(0, 7) == 0) ? 32'd3 : 32'd2;
    s.me    = ($urandom_range(0, 7) == 0) ? m_pc + 32'd4 : m_pc;
    return s;
  endfunction

  vec_t vecs[$];

  initial begin
    // reset, nominal
    vecs.push_back('{st(0,0,0,0,0,0,0),           ex(0,4'b0000,0,0)});
    vecs.push_back('{st(1,1,1,32'h100,0,0,0),     ex(1,4'b0000,1,0)});
    vecs.push_back('{st(1,0,0,0,0,0,0),           ex(1,4'b0000,1,0)});
    vecs.push_back('{st(1,0,0,0,0,0,0),           ex(1,4'b0000,1,0)});
    vecs.push_back('{st(1,1,0,32'h1000,0,2,32'h100), ex(0,4'b0000,1,1)});
    vecs.push_back('{st(1,0,0,0,0,0,0),           ex(0,4'b0000,1,1)});
    // wrong mcause and mepc
    vecs.push_back('{st(0,0,0,0,0,0,0),           ex(0,4'b0000,0,0)});
    vecs.push_back('{st(1,1,1,32'h100,0,0,0),     ex(1,4'b0000,1,0)});
    vecs.push_back('{st(1,0,0,0,0,0,0),           ex(1,4'b0000,1,0)});
    vecs.push_back('{st(1,0,0,0,0,0,0),           ex(1,4'b0000,1,0)});
    vecs.push_back('{st(1,1,0,32'h1000,0,3,32'h104), ex(0,4'b0110,1,0)});
    // wrong vector, earliest handler retirement
    vecs.push_back('{st(1,1,1,32'h200,0,0,0),     ex(1,4'b0110,2,0)});
    vecs.push_back('{st(1,1,0,32'h1004,0,2,32'h200), ex(0,4'b1110,2,0)});
    // timeout
    vecs.push_back('{st(0,0,0,0,0,0,0),           ex(0,4'b0000,0,0)});
    vecs.push_back('{st(1,1,1,32'h300,0,0,0),     ex(1,4'b0000,1,0)});
    vecs.push_back('{st(1,0,0,0,0,0,0),           ex(1,4'b0000,1,0)});
    vecs.push_back('{st(1,0,0,0,0,0,0),           ex(1,4'b0000,1,0)});
    vecs.push_back('{st(1,0,0,0,0,0,0),           ex(1,4'b0000,1,0)});
    vecs.push_back('{st(1,0,0,0,0,0,0),           ex(0,4'b0001,1,0)});
    vecs.push_back('{st(1,0,0,0,0,0,0),           ex(0,4'b0001,1,0)});
    // handler in the TIMEOUT-th cycle
    vecs.push_back('{st(0,0,0,0,0,0,0),           ex(0,4'b0000,0,0)});
    vecs.push_back('{st(1,1,1,32'h300,0,0,0),     ex(1,4'b0000,1,0)});
    vecs.push_back('{st(1,0,0,0,0,0,0),           ex(1,4'b0000,1,0)});
    vecs.push_back('{st(1,0,0,0,0,0,0),           ex(1,4'b0000,1,0)});
    vecs.push_back('{st(1,0,0,0,0,0,0),           ex(1,4'b0000,1,0)});
    vecs.push_back('{st(1,1,0,32'h1000,0,2,32'h300), ex(0,4'b0000,1,1)});
    // nested illegal in handler
    vecs.push_back('{st(0,0,0,0,0,0,0),           ex(0,4'b0000,0,0)});
    vecs.push_back('{st(1,1,1,32'h100,0,0,0),     ex(1,4'b0000,1,0)});
    vecs.push_back('{st(1,0,0,0,0,0,0),           ex(1,4'b0000,1,0)});
    vecs.push_back('{st(1,1,1,32'h1000,0,2,32'h100), ex(1,4'b0000,2,1)});
    vecs.push_back('{st(1,0,0,0,0,0,0),           ex(1,4'b0000,2,1)});
    vecs.push_back('{st(1,1,0,32'h1000,0,2,32'h1000), ex(0,4'b0000,2,2)});
    // debug abort, debug blocks trigger
    vecs.push_back('{st(0,0,0,0,0,0,0),           ex(0,4'b0000,0,0)});
    vecs.push_back('{st(1,1,1,32'h100,0,0,0),     ex(1,4'b0000,1,0)});
    vecs.push_back('{st(1,0,0,0,1,0,0),           ex(0,4'b0000,1,0)});
    vecs.push_back('{st(1,0,0,0,0,0,0),           ex(0,4'b0000,1,0)});
    vecs.push_back('{st(1,1,1,32'h100,1,0,0),     ex(0,4'b0000,1,0)});
    // reset mid-wait, then a normal check
    vecs.push_back('{st(1,1,1,32'h100,0,0,0),     ex(1,4'b0000,2,0)});
    vecs.push_back('{st(1,0,0,0,0,0,0),           ex(1,4'b0000,2,0)});
    vecs.push_back('{st(0,1,0,32'h1000,0,3,0),    ex(0,4'b0000,0,0)});
    vecs.push_back('{st(1,1,1,32'h400,0,0,0),     ex(1,4'b0000,1,0)});
    vecs.push_back('{st(1,1,0,32'h1000,0,2,32'h400), ex(0,4'b0000,1,1)});

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].s);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp);
    end

    // debug abort landing on the would-be timeout cycle stays silent
    applyStimulus(st(0,0,0,0,0,0,0));
    applyStimulus(st(1,1,1,32'h500,0,0,0));
    for (int i = 0; i < 3; i++) applyStimulus(st(1,0,0,0,0,0,0));
    checkOutput("pre_abort_busy", ex(1,4'b0000,1,0));
    applyStimulus(st(1,0,0,0,1,0,0));
    checkOutput("abort_at_timeout", ex(0,4'b0000,1,0));
    // legal retirement in IDLE does not arm
    applyStimulus(st(1,1,0,32'h600,0,0,0));
    checkOutput("legal_no_arm", ex(0,4'b0000,1,0));

    // randomized run against the reference model
    model_step(st(0,0,0,0,0,0,0));
    applyStimulus(st(0,0,0,0,0,0,0));
    checkOutput("rand_reset", model_exp());
    for (int i = 0; i < 3000; i++) begin
      stim_t s;
      s = random_stim();
      model_step(s);
      applyStimulus(s);
      checkOutput($sformatf("rand%0d", i), model_exp());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
